i2c_master_arbiter: RTL and testbench
=====================================

# i2c_master_arbiter

Two-requester arbiter and transaction sequencer in front of the I2C master core. It grants the single master core to one requester at a time using round-robin order. For the granted transfer it drives the core's command byte and slave address, tracks completion, and reports done/error to the winner. A watchdog aborts hung transfers by pulsing the core's soft reset.

## Interface
- DATA_SIZE, 8, data width of the core (kept for interface alignment; data does not pass through this block)
- ADDR_SIZE, 8, width of slave address + R/W bit; bit 0 is R/W (1 = read)
- TMO_W, 16, watchdog counter width

- i2c_core_clk_i  in  1  core clock; all logic on its rising edge
- reset_ni  in  1  asynchronous, active-low reset
- req_i  in  2  per-requester transfer request (level, held until done)
- addr_rw_i  in  2*ADDR_SIZE  per-requester address+R/W; requester n uses slice [n*ADDR_SIZE +: ADDR_SIZE]
- rpt_i  in  2  per-requester repeat-start request (chain the next transfer without releasing the grant)
- tmo_limit_i  in  TMO_W  watchdog limit in cycles; 0 = watchdog disabled
- core_busy_i  in  1  master core has started the transfer
- core_done_i  in  1  one-cycle pulse: core finished (stop issued)
- core_nack_i  in  1  valid with core_done_i: slave NACKed
- core_command_o  out  8  to core command input: [7] reset_n, [6] enable, [5] repeat_start, [4] rw, [3:0] = 0
- core_addr_rw_o  out  ADDR_SIZE  to core slave_addr_rw input
- grant_o  out  2  one-hot grant, 0 when idle
- done_o  out  2  one-cycle completion pulse to the granted requester
- err_o  out  2  one-cycle error pulse, coincident with done_o (NACK or timeout)

## Operation
- All outputs are registered. Reset values: grant_o 0, done_o 0, err_o 0, core_addr_rw_o 0, core_command_o 8'h00 (core held in reset). State IDLE; round-robin pointer = requester 0 has priority.
- States: IDLE, START, BUSY, RELEASE, ABORT.
- IDLE
  - core_command_o = 8'h80.
  - If any req_i is set, the winner is the pointer-preferred requester when it requests, otherwise the other one.
  - Transition to START: latch the winner's addr_rw into core_addr_rw_o, set grant_o, set command = {1, 1, 0, addr_rw[0], 4'h0}.
- START
  - Hold the command until core_busy_i = 1, then go to BUSY. enable stays 1.
- BUSY
  - Command unchanged.
  - On core_done_i, pulse done_o for the winner, with err_o = core_nack_i.
  - If rpt_i[winner] and req_i[winner] are both 1 at the done cycle: return to START with command[5] = 1 and the address re-latched. Grant and pointer are unchanged.
  - Otherwise go to RELEASE.
- RELEASE (1 cycle): clear grant_o, command = 8'h80, pointer = other requester, go to IDLE.
- Watchdog
  - Counter clears on entry to START and counts each cycle in START/BUSY.
  - When the counter equals tmo_limit_i (limit ≠ 0), go to ABORT.
- ABORT (1 cycle): core_command_o = 8'h00, done_o and err_o pulse for the winner, then RELEASE.
- Deassertion of req_i during START/BUSY is ignored; the transfer completes. Changes to addr_rw_i after the latch are ignored.
- core_done_i outside BUSY is ignored. If core_done_i and timeout occur in the same cycle, done wins (normal completion, err_o = core_nack_i).

## Timing
- Request sampled in IDLE at edge N produces grant_o and command enable at edge N+1.
- core_done_i at edge M gives done_o at M+1. In the non-chained case grant_o drops at M+2, and a new grant is possible at M+3.
- Chained repeat start: START is re-entered at M+1 with command[5] = 1 at M+1. There is no idle gap.
- Timeout with limit L: ABORT occurs L+1 cycles after START entry.
- reset_ni low at any time immediately forces all outputs to reset values; no done_o is generated for the killed transfer.

## Test plan
- Single request: req_i = 01, addr 0x50 write → grant_o = 01 next cycle. Command 8'hC0 until busy. After core_done_i: done_o = 01, err_o = 00, grant_o = 0 two cycles later.
- Simultaneous: req_i = 11 from reset → requester 0 served first, then requester 1 (grant 10). With both still requesting, the third grant goes to requester 0.
- NACK: core_done_i with core_nack_i = 1 → done_o and err_o both pulse for the winner in the same cycle.
- Repeat start: requester 1 with rpt_i[1] = 1, addr 0xA1 → after done, command = 8'hF0, grant_o stays 10 with no IDLE cycle.
- Timeout: tmo_limit_i = 20, core_busy_i never set → ABORT at cycle 21. command = 8'h00 for 1 cycle, done_o = err_o = winner, then IDLE with command 8'h80. tmo_limit_i = 0 → no abort after 1000 cycles.
- Reset mid-BUSY: reset_ni low → grant_o = 0 and command = 8'h00 immediately. After release, IDLE with requester 0 preferred.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin two-requester arbiter and transfer sequencer for the I2C master core
module i2c_master_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter int TMO_W     = 16
) (
    input  logic                   i2c_core_clk_i,
    input  logic                   reset_ni,
    input  logic [1:0]             req_i,
    input  logic [2*ADDR_SIZE-1:0] addr_rw_i,
    input  logic [1:0]             rpt_i,
    input  logic [TMO_W-1:0]       tmo_limit_i,
    input  logic                   core_busy_i,
    input  logic                   core_done_i,
    input  logic                   core_nack_i,
    output logic [7:0]             core_command_o,
    output logic [ADDR_SIZE-1:0]   core_addr_rw_o,
    output logic [1:0]             grant_o,
    output logic [1:0]             done_o,
    output logic [1:0]             err_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        RELEASE,
        ABORT
    } state_t;

    // Command byte layout: [7] reset_n, [6] enable, [5] repeat_start, [4] rw
    localparam logic [7:0] CMD_OFF  = 8'h00;
    localparam logic [7:0] CMD_IDLE = 8'h80;

    state_t               state;
    logic                 ptr;
    logic                 winner;
    logic [TMO_W-1:0]     tmo_cnt;

    logic                 pick;
    logic [ADDR_SIZE-1:0] pick_addr;
    logic [ADDR_SIZE-1:0] win_addr;
    logic                 timeout;
    logic                 unused_data_size;

    assign unused_data_size = ^DATA_SIZE;

    // The pointer-preferred requester wins if it asks, otherwise the other one.
    assign pick      = req_i[ptr] ? ptr : ~ptr;
    assign pick_addr = pick   ? addr_rw_i[2*ADDR_SIZE-1:ADDR_SIZE] : addr_rw_i[ADDR_SIZE-1:0];
    assign win_addr  = winner ? addr_rw_i[2*ADDR_SIZE-1:ADDR_SIZE] : addr_rw_i[ADDR_SIZE-1:0];
    assign timeout   = (tmo_limit_i != '0) && (tmo_cnt == tmo_limit_i);

    always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            winner         <= 1'b0;
            tmo_cnt        <= '0;
            core_command_o <= CMD_OFF;
            core_addr_rw_o <= '0;
            grant_o        <= 2'b00;
            done_o         <= 2'b00;
            err_o          <= 2'b00;
        end else begin
            done_o <= 2'b00;
            err_o  <= 2'b00;
            case (state)
                IDLE: begin
                    core_command_o <= CMD_IDLE;
                    if (|req_i) begin
                        winner         <= pick;
                        grant_o        <= pick ? 2'b10 : 2'b01;
                        core_addr_rw_o <= pick_addr;
                        core_command_o <= {3'b110, pick_addr[0], 4'h0};
                        tmo_cnt        <= '0;
                        state          <= START;
                    end
                end
                START: begin
                    if (timeout) begin
                        core_command_o <= CMD_OFF;
                        done_o         <= grant_o;
                        err_o          <= grant_o;
                        state          <= ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (core_busy_i) begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // A completion in the same cycle as the timeout is a normal finish.
                    if (core_done_i) begin
                        done_o <= grant_o;
                        err_o  <= core_nack_i ? grant_o : 2'b00;
                        if (rpt_i[winner] && req_i[winner]) begin
                            core_addr_rw_o <= win_addr;
                            core_command_o <= {3'b111, win_addr[0], 4'h0};
                            tmo_cnt        <= '0;
                            state          <= START;
                        end else begin
                            state <= RELEASE;
                        end
                    end else if (timeout) begin
                        core_command_o <= CMD_OFF;
                        done_o         <= grant_o;
                        err_o          <= grant_o;
                        state          <= ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ABORT: begin
                    core_command_o <= CMD_IDLE;
                    state          <= RELEASE;
                end
                RELEASE: begin
                    grant_o        <= 2'b00;
                    core_command_o <= CMD_IDLE;
                    ptr            <= ~winner;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - self-checking bench for i2c_master_arbiter
module tb_i2c_master_arbiter;

    localparam int AW = 8;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [2*AW-1:0] addr_rw = '0;
    logic [1:0]    rpt = 2'b00;
    logic [TW-1:0] tmo_limit = '0;
    logic          core_busy = 1'b0;
    logic          core_done = 1'b0;
    logic          core_nack = 1'b0;
    logic [7:0]    cmd;
    logic [AW-1:0] addr_o;
    logic [1:0]    grant;
    logic [1:0]    done;
    logic [1:0]    err;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    i2c_master_arbiter #(.DATA_SIZE(8), .ADDR_SIZE(AW), .TMO_W(TW)) dut (
        .i2c_core_clk_i (clk),
        .reset_ni       (rst_n),
        .req_i          (req),
        .addr_rw_i      (addr_rw),
        .rpt_i          (rpt),
        .tmo_limit_i    (tmo_limit),
        .core_busy_i    (core_busy),
        .core_done_i    (core_done),
        .core_nack_i    (core_nack),
        .core_command_o (cmd),
        .core_addr_rw_o (addr_o),
        .grant_o        (grant),
        .done_o         (done),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] onehot(input int w);
        return (w != 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] start_cmd(input logic r, input logic [7:0] a);
        return {2'b11, r, a[0], 4'h0};
    endfunction

    function automatic int model_winner(input logic [1:0] rv);
        return rv[ptr_m] ? ptr_m : 1 - ptr_m;
    endfunction

    task automatic set_addr(input int r, input logic [7:0] a);
        addr_rw[r*AW +: AW] = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (grant !== 2'b00 || done !== 2'b00 || err !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: grant=%b done=%b err=%b expected 00 00 00", grant, done, err);
        end
        checks++;
        if (cmd !== 8'h00 || addr_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_cmd: cmd=%h addr=%h expected 00 00", cmd, addr_o);
        end
        rst_n = 1'b1;
        ptr_m = 0;
        tick();
        checks++;
        if (cmd !== 8'h80 || grant !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: cmd=%h grant=%b expected 80 00", cmd, grant);
        end
    endtask

    task automatic test_single();
        int r;
        int d;
        logic [7:0] a;
        logic nk;
        logic hold_ok;
        for (int i = 0; i < 4; i++) begin
            r  = (i == 0) ? 0 : int'($urandom_range(0, 1));
            a  = (i == 0) ? 8'h50 : 8'($urandom);
            nk = (i == 1) ? 1'b1 : ((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
            set_addr(r, a);
            req = onehot(r);
            tick();
            checks++;
            if (grant !== onehot(r) || cmd !== start_cmd(1'b0, a) || addr_o !== a) begin
                errors++;
                $display("FAIL single_grant i=%0d: grant=%b cmd=%h addr=%h expected %b %h %h",
                         i, grant, cmd, addr_o, onehot(r), start_cmd(1'b0, a), a);
            end
            addr_rw = 16'($urandom);
            d = int'($urandom_range(1, 4));
            hold_ok = 1'b1;
            for (int k = 0; k < d; k++) begin
                tick();
                if (cmd !== start_cmd(1'b0, a) || addr_o !== a) hold_ok = 1'b0;
            end
            checks++;
            if (!hold_ok) begin
                errors++;
                $display("FAIL single_hold i=%0d: cmd=%h addr=%h expected %h %h", i, cmd, addr_o, start_cmd(1'b0, a), a);
            end
            core_busy = 1'b1;
            tick();
            core_busy = 1'b0;
            repeat (int'($urandom_range(0, 3))) tick();
            core_done = 1'b1;
            core_nack = nk;
            tick();
            core_done = 1'b0;
            core_nack = 1'b0;
            req = 2'b00;
            checks++;
            if (done !== onehot(r) || err !== (nk ? onehot(r) : 2'b00) || grant !== onehot(r)) begin
                errors++;
                $display("FAIL single_done i=%0d: done=%b err=%b grant=%b expected %b %b %b",
                         i, done, err, grant, onehot(r), nk ? onehot(r) : 2'b00, onehot(r));
            end
            tick();
            checks++;
            if (grant !== 2'b00 || done !== 2'b00 || cmd !== 8'h80) begin
                errors++;
                $display("FAIL single_release i=%0d: grant=%b done=%b cmd=%h expected 00 00 80", i, grant, done, cmd);
            end
            ptr_m = 1 - r;
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] a [2];
        int w;
        rst_n = 1'b0;
        tick();
        a[0] = 8'($urandom);
        a[1] = 8'($urandom);
        set_addr(0, a[0]);
        set_addr(1, a[1]);
        req = 2'b11;
        rst_n = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < 3; i++) begin
            w = model_winner(req);
            tick();
            checks++;
            if (grant !== onehot(w) || addr_o !== a[w]) begin
                errors++;
                $display("FAIL simul_grant n=%0d: grant=%b addr=%h expected %b %h", i, grant, addr_o, onehot(w), a[w]);
            end
            core_busy = 1'b1;
            tick();
            core_busy = 1'b0;
            core_done = 1'b1;
            tick();
            core_done = 1'b0;
            checks++;
            if (done !== onehot(w) || err !== 2'b00) begin
                errors++;
                $display("FAIL simul_done n=%0d: done=%b err=%b expected %b 00", i, done, err, onehot(w));
            end
            tick();
            ptr_m = 1 - w;
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_repeat_start();
        logic [7:0] b;
        set_addr(1, 8'hA1);
        req = 2'b10;
        rpt = 2'b10;
        tick();
        checks++;
        if (grant !== 2'b10 || cmd !== 8'hD0) begin
            errors++;
            $display("FAIL rpt_grant: grant=%b cmd=%h expected 10 d0", grant, cmd);
        end
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (done !== 2'b10 || grant !== 2'b10 || cmd !== 8'hF0 || addr_o !== 8'hA1) begin
            errors++;
            $display("FAIL rpt_chain: done=%b grant=%b cmd=%h addr=%h expected 10 10 f0 a1", done, grant, cmd, addr_o);
        end
        b = 8'($urandom);
        set_addr(1, b);
        rpt = 2'b00;
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        req = 2'b00;
        checks++;
        if (done !== 2'b10 || grant !== 2'b10 || addr_o !== 8'hA1) begin
            errors++;
            $display("FAIL rpt_second: done=%b grant=%b addr=%h expected 10 10 a1", done, grant, addr_o);
        end
        tick();
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL rpt_release: grant=%b expected 00", grant);
        end
        ptr_m = 0;
    endtask

    task automatic test_timeout();
        int r;
        int lim;
        logic [7:0] a;
        logic quiet;
        for (int i = 0; i < 3; i++) begin
            r   = int'($urandom_range(0, 1));
            lim = (i == 0) ? 20 : int'($urandom_range(1, 30));
            a   = 8'($urandom);
            set_addr(r, a);
            tmo_limit = 16'(lim);
            req = onehot(r);
            tick();
            quiet = 1'b1;
            for (int k = 0; k < lim; k++) begin
                tick();
                if (cmd !== start_cmd(1'b0, a) || done !== 2'b00) quiet = 1'b0;
            end
            checks++;
            if (!quiet) begin
                errors++;
                $display("FAIL tmo_early lim=%0d: cmd=%h done=%b expected %h 00", lim, cmd, done, start_cmd(1'b0, a));
            end
            tick();
            req = 2'b00;
            checks++;
            if (cmd !== 8'h00 || done !== onehot(r) || err !== onehot(r)) begin
                errors++;
                $display("FAIL tmo_abort lim=%0d: cmd=%h done=%b err=%b expected 00 %b %b", lim, cmd, done, err, onehot(r), onehot(r));
            end
            tick();
            checks++;
            if (cmd !== 8'h80 || done !== 2'b00 || err !== 2'b00) begin
                errors++;
                $display("FAIL tmo_after lim=%0d: cmd=%h done=%b err=%b expected 80 00 00", lim, cmd, done, err);
            end
            tick();
            checks++;
            if (grant !== 2'b00) begin
                errors++;
                $display("FAIL tmo_release: grant=%b expected 00", grant);
            end
            ptr_m = 1 - r;
        end
        // done and timeout landing on the same edge
        r   = int'($urandom_range(0, 1));
        lim = int'($urandom_range(2, 10));
        tmo_limit = 16'(lim);
        req = onehot(r);
        core_busy = 1'b1;
        tick();
        tick();
        core_busy = 1'b0;
        repeat (lim - 1) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        req = 2'b00;
        checks++;
        if (done !== onehot(r) || err !== 2'b00 || cmd === 8'h00) begin
            errors++;
            $display("FAIL tmo_tie: done=%b err=%b cmd=%h expected %b 00 non-00", done, err, cmd, onehot(r));
        end
        tick();
        tick();
        ptr_m = 1 - r;
        // watchdog disabled
        tmo_limit = '0;
        r = int'($urandom_range(0, 1));
        req = onehot(r);
        tick();
        quiet = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (done !== 2'b00 || cmd[7:6] !== 2'b11 || grant !== onehot(r)) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL tmo_disabled: done=%b cmd=%h grant=%b expected 00 c0/d0 %b", done, cmd, grant, onehot(r));
        end
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        req = 2'b00;
        tick();
        ptr_m = 1 - r;
    endtask

    task automatic test_reset_mid_busy();
        logic quiet;
        req = 2'b01;
        tick();
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        ptr_m = 1;
        req = 2'b01;
        tick();
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00 || cmd !== 8'h00 || done !== 2'b00) begin
            errors++;
            $display("FAIL midreset_async: grant=%b cmd=%h done=%b expected 00 00 00", grant, cmd, done);
        end
        req = 2'b11;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rst_n = 1'b1;
        ptr_m = 0;
        tick();
        checks++;
        if (grant !== onehot(model_winner(2'b11)) || done !== 2'b00) begin
            errors++;
            $display("FAIL midreset_prio: grant=%b done=%b expected %b 00", grant, done, onehot(model_winner(2'b11)));
        end
        quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done !== 2'b00) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL midreset_nodone: done=%b expected 00", done);
        end
        req = 2'b00;
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        ptr_m = 1;
    endtask

    task automatic test_back_to_back();
        logic [1:0] rv;
        logic [7:0] a [2];
        logic [7:0] exp_cmd;
        logic nk;
        logic hold_ok;
        int w;
        int c;
        tmo_limit = '0;
        rpt = 2'b00;
        for (int it = 0; it < 25; it++) begin
            rv = 2'($urandom_range(1, 3));
            a[0] = 8'($urandom);
            a[1] = 8'($urandom);
            set_addr(0, a[0]);
            set_addr(1, a[1]);
            req = rv;
            w = model_winner(rv);
            exp_cmd = start_cmd(1'b0, a[w]);
            tick();
            checks++;
            if (grant !== onehot(w) || addr_o !== a[w] || cmd !== exp_cmd) begin
                errors++;
                $display("FAIL b2b_grant it=%0d: grant=%b addr=%h cmd=%h expected %b %h %h",
                         it, grant, addr_o, cmd, onehot(w), a[w], exp_cmd);
            end
            c = int'($urandom_range(0, 2));
            for (int j = 0; j <= c; j++) begin
                hold_ok = 1'b1;
                repeat (int'($urandom_range(0, 3))) begin
                    tick();
                    if (cmd !== exp_cmd || done !== 2'b00) hold_ok = 1'b0;
                end
                checks++;
                if (!hold_ok) begin
                    errors++;
                    $display("FAIL b2b_hold it=%0d j=%0d: cmd=%h done=%b expected %h 00", it, j, cmd, done, exp_cmd);
                end
                core_busy = 1'b1;
                tick();
                core_busy = 1'b0;
                repeat (int'($urandom_range(0, 3))) tick();
                nk = 1'($urandom_range(0, 1));
                if (j < c) begin
                    a[w] = 8'($urandom);
                    set_addr(w, a[w]);
                    rpt[w] = 1'b1;
                end else begin
                    rpt = 2'b00;
                end
                core_done = 1'b1;
                core_nack = nk;
                tick();
                core_done = 1'b0;
                core_nack = 1'b0;
                checks++;
                if (done !== onehot(w) || err !== (nk ? onehot(w) : 2'b00) || grant !== onehot(w)) begin
                    errors++;
                    $display("FAIL b2b_done it=%0d j=%0d: done=%b err=%b grant=%b expected %b %b %b",
                             it, j, done, err, grant, onehot(w), nk ? onehot(w) : 2'b00, onehot(w));
                end
                if (j < c) begin
                    exp_cmd = start_cmd(1'b1, a[w]);
                    checks++;
                    if (cmd !== exp_cmd || addr_o !== a[w]) begin
                        errors++;
                        $display("FAIL b2b_chain it=%0d j=%0d: cmd=%h addr=%h expected %h %h", it, j, cmd, addr_o, exp_cmd, a[w]);
                    end
                end
            end
            rpt = 2'b00;
            tick();
            checks++;
            if (grant !== 2'b00 || done !== 2'b00) begin
                errors++;
                $display("FAIL b2b_release it=%0d: grant=%b done=%b expected 00 00", it, grant, done);
            end
            ptr_m = 1 - w;
        end
        req = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_repeat_start();
        test_timeout();
        test_reset_mid_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
